// File: rtl/bin2bcd_seq_if.sv
// bin2bcd_seq_if: request/result bundle between a binary source and the BCD converter.
interface bin2bcd_seq_if #(
   parameter int W = 8,
   parameter int D = 3
) ();
   logic           start;
   logic [W-1:0]   bin;
   logic           ready;
   logic           done;
   logic [4*D-1:0] bcd;
   logic [D-1:0]   blank;

   modport master (output start, bin, input ready, done, bcd, blank);
   modport slave  (input start, bin, output ready, done, bcd, blank);
endinterface

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential double-dabble converter, one iteration per clock,
// with a leading-zero blank mask for the display stage.
module bin2bcd_seq #(
   parameter int W = 8,
   parameter int D = 3
) (
   input logic          clk,
   input logic          rst,
   bin2bcd_seq_if.slave bus
);
   localparam int CW = $clog2(W + 1);

   function automatic longint pow10(int n);
      longint p = 1;
      for (int i = 0; i < n; i++) p *= 10;
      return p;
   endfunction

   if (pow10(D) <= (longint'(1) << W) - 1) begin : g_bad_digits
      $error("bin2bcd_seq: D=%0d digits cannot hold a %0d-bit value", D, W);
   end

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t         state, state_nx;
   logic [4*D-1:0] scr, scr_nx, adj, bcd_r;
   logic [W-1:0]   sh, sh_nx;
   logic [CW-1:0]  cnt;
   logic [D-1:0]   blank_r, blank_nx;
   logic           last, z;

   assign last = cnt == CW'(1);

   always_comb begin
      adj = '0;
      for (int i = 0; i < D; i++)
         adj[4*i +: 4] = scr[4*i +: 4] > 4'd4 ? scr[4*i +: 4] + 4'd3 : scr[4*i +: 4];
      {scr_nx, sh_nx} = {adj, sh} << 1;
      // a digit is blanked only if it and every digit above it are zero
      z = 1'b1;
      blank_nx = '0;
      for (int i = D - 1; i > 0; i--) begin
         z = z & (scr_nx[4*i +: 4] == 4'd0);
         blank_nx[i] = z;
      end
   end

   always_comb begin
      state_nx = state;
      state_nx = state == IDLE  ? (bus.start ? SHIFT : IDLE) :
                 state == SHIFT ? (last ? DONE : SHIFT) : IDLE;
   end

   always_ff @(posedge clk or posedge rst)
      if (rst) state <= IDLE;
      else     state <= state_nx;

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         scr     <= '0;
         sh      <= '0;
         cnt     <= '0;
         bcd_r   <= '0;
         blank_r <= {D{1'b1}} << 1;
      end else if (state == IDLE && bus.start) begin
         scr <= '0;
         sh  <= bus.bin;
         cnt <= CW'(W);
      end else if (state == SHIFT) begin
         scr <= scr_nx;
         sh  <= sh_nx;
         cnt <= cnt - CW'(1);
         if (last) begin
            bcd_r   <= scr_nx;
            blank_r <= blank_nx;
         end
      end

   assign bus.ready = state == IDLE;
   assign bus.done  = state == DONE;
   assign bus.bcd   = bcd_r;
   assign bus.blank = blank_r;
endmodule

// File: doc/bin2bcd_seq.md
BIN2BCD_SEQ -- requirements
Module: bin2bcd_seq

Interface
REQ-001 Parameter W, default 8: binary input width.
REQ-002 Parameter D, default 3: number of BCD output digits; legal only when 10^D > 2^W-1 (elaboration error otherwise).
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 start  input  1  conversion request, sampled on clk rising edge.
REQ-006 bin  input  W  unsigned binary value, e.g. stopwatch count.
REQ-007 ready  output  1  high when block can accept start (IDLE state).
REQ-008 done  output  1  one-cycle pulse, result valid on bcd/blank.
REQ-009 bcd  output  4*D  packed BCD result, digit 0 (units) in bits [3:0].
REQ-010 blank  output  D  leading-zero mask for display stage; bit i=1 means digit i is a leading zero.

Function
REQ-011 FSM states SHALL be IDLE, SHIFT, DONE; encoding free.
REQ-012 ready SHALL equal (state == IDLE), combinational from state register only.
REQ-013 Start accepted only when start=1 and state=IDLE at a rising edge; bin captured into internal shift register at that edge; state -> SHIFT; iteration counter loaded with W.
REQ-014 start while state is SHIFT or DONE SHALL be ignored (no queuing, no restart, no effect on in-flight result).
REQ-015 Changes on bin after acceptance SHALL NOT affect the result.
REQ-016 SHIFT: one double-dabble iteration per cycle -- every BCD scratch digit >=5 gets +3 (4-bit add, no carry out of digit), then scratch/binary concatenation shifted left by 1.
REQ-017 After exactly W iterations, state -> DONE; bcd and blank registers load final scratch value at that same edge.
REQ-018 done SHALL be high exactly while state=DONE (one cycle); DONE -> IDLE unconditionally at next edge.
REQ-019 Latency: start accepted at edge k -> done high in the cycle after edge k+W; ready high again after edge k+W+1.
REQ-020 Back-to-back: start held high continuously SHALL yield one conversion per W+2 cycles.
REQ-021 bcd and blank SHALL hold last result between done pulses; never show intermediate scratch values.
REQ-022 blank[D-1..1]: bit i = 1 iff digit i and all higher digits are 0; blank[0] SHALL always be 0 (units digit never blanked).
REQ-023 Every output BCD digit SHALL be in range 0-9 for every legal bin value, including 0 and 2^W-1.
REQ-024 No combinational path from start or bin to any output.

Reset
REQ-025 rst asserted SHALL immediately force: state=IDLE, ready=1, done=0, bcd=0, blank = all ones except bit 0 (3'b110 for D=3), internal scratch and counter = 0.
REQ-026 rst mid-conversion SHALL abort it; no done pulse for the aborted request; bcd keeps reset value.
REQ-027 start during rst SHALL be ignored; first acceptable edge is the first rising edge after rst deasserts.

Verification
REQ-028 bin=255, start 1 cycle -> done pulse exactly 8 cycles after accept edge (9th edge), bcd=12'h255, blank=3'b000, ready=1 next cycle.
REQ-029 bin=0 -> bcd=12'h000, blank=3'b110; bin=9 -> bcd=12'h009, blank=3'b110; bin=31 -> bcd=12'h031, blank=3'b100.
REQ-030 bin=100 accepted, bin changed to 7 and start pulsed again during SHIFT -> single done, bcd=12'h100, blank=3'b000; no second conversion.
REQ-031 Accept bin=200, assert rst at 4th SHIFT cycle -> ready=1, done stays 0, bcd=0, blank=3'b110; subsequent bin=42 conversion -> bcd=12'h042, blank=3'b100.
REQ-032 start held high with bin stepping 0..255 -> one done every 10 cycles, each bcd matches decimal of bin at its accept edge; exhaustive check of all 256 values.
